// File: rtl/sqrt_dispatch_if.sv
// rtl/sqrt_dispatch_if.sv - upstream, sqrt_int and downstream signals of sqrt_dispatch
interface sqrt_dispatch_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             sq_start;
    logic [WIDTH-1:0] sq_rad;
    logic             sq_busy;
    logic             sq_valid;
    logic [WIDTH-1:0] sq_root;
    logic [WIDTH-1:0] sq_rem;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_rad;
    logic [WIDTH-1:0] out_root;
    logic [WIDTH-1:0] out_rem;
    logic [CW-1:0]    count;

    modport slave (
        input  in_valid, in_data, sq_busy, sq_valid, sq_root, sq_rem, out_ready,
        output in_ready, sq_start, sq_rad, out_valid, out_rad, out_root, out_rem, count
    );

    modport master (
        output in_valid, in_data, sq_busy, sq_valid, sq_root, sq_rem, out_ready,
        input  in_ready, sq_start, sq_rad, out_valid, out_rad, out_root, out_rem, count
    );
endinterface

// File: rtl/sqrt_dispatch.sv
// rtl/sqrt_dispatch.sv - radicand FIFO feeding one sqrt_int operation at a time
module sqrt_dispatch_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
endmodule

module sqrt_dispatch #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    sqrt_dispatch_if.slave bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] head;
    logic             push;
    logic             pop;
    logic             sq_start_r;
    logic [WIDTH-1:0] sq_rad_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] out_rad_r;
    logic [WIDTH-1:0] out_root_r;
    logic [WIDTH-1:0] out_rem_r;

    assign bus.in_ready = (count < FULL_COUNT);
    assign push = bus.in_valid && bus.in_ready;
    assign pop  = (state == S_IDLE) && (count != '0) && !bus.sq_busy;

    sqrt_dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (bus.in_data),
        .pop   (pop),
        .rdata (head),
        .count (count)
    );

    // sq_valid only matters in S_WAIT, so stray results from an aborted op are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            sq_start_r  <= 1'b0;
            sq_rad_r    <= '0;
            out_valid_r <= 1'b0;
            out_rad_r   <= '0;
            out_root_r  <= '0;
            out_rem_r   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        sq_rad_r   <= head;
                        sq_start_r <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    sq_start_r <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.sq_valid) begin
                        out_rad_r   <= sq_rad_r;
                        out_root_r  <= bus.sq_root;
                        out_rem_r   <= bus.sq_rem;
                        out_valid_r <= 1'b1;
                        state       <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.sq_start  = sq_start_r;
    assign bus.sq_rad    = sq_rad_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_rad   = out_rad_r;
    assign bus.out_root  = out_root_r;
    assign bus.out_rem   = out_rem_r;
    assign bus.count     = count;
endmodule

// File: tb/tb_sqrt_dispatch.sv
// tb/tb_sqrt_dispatch.sv - directed vector bench for sqrt_dispatch
module tb_sqrt_dispatch;
    localparam int W = 8;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int rad;
        int root;
        int rem;
    } vec_t;

    vec_t burst [4];
    vec_t full  [6];

    sqrt_dispatch_if #(.WIDTH(W), .DEPTH(D)) bus ();

    sqrt_dispatch #(.WIDTH(W), .DEPTH(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Stand-in for sqrt_int: integer square root of whatever radicand is presented.
    function automatic int isqrt(input int x);
        int r = 0;
        while ((r + 1) * (r + 1) <= x) r++;
        return r;
    endfunction

    task automatic wait_start();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.sq_start) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("start_seen", int'(ok), 1);
    endtask

    task automatic serve(input vec_t v, input bit need_start);
        int r;
        if (need_start) begin
            wait_start();
            check("issue_rad", int'(bus.sq_rad), v.rad);
            bus.sq_busy = 1'b1;
            @(negedge clk);
            check("start_one_cycle", int'(bus.sq_start), 0);
        end
        r = isqrt(int'(bus.sq_rad));
        bus.sq_valid = 1'b1;
        bus.sq_busy  = 1'b0;
        bus.sq_root  = W'(r);
        bus.sq_rem   = W'(int'(bus.sq_rad) - r * r);
        @(negedge clk);
        bus.sq_valid = 1'b0;
        check("out_valid", int'(bus.out_valid), 1);
        check("out_rad", int'(bus.out_rad), v.rad);
        check("out_root", int'(bus.out_root), v.root);
        check("out_rem", int'(bus.out_rem), v.rem);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_count"}, int'(bus.count), 0);
        check({tag, "_in_ready"}, int'(bus.in_ready), 1);
        check({tag, "_sq_start"}, int'(bus.sq_start), 0);
        check({tag, "_sq_rad"}, int'(bus.sq_rad), 0);
        check({tag, "_out_valid"}, int'(bus.out_valid), 0);
        check({tag, "_out_rad"}, int'(bus.out_rad), 0);
        check({tag, "_out_root"}, int'(bus.out_root), 0);
        check({tag, "_out_rem"}, int'(bus.out_rem), 0);
    endtask

    initial begin
        burst[0] = '{0, 0, 0};
        burst[1] = '{200, 14, 4};
        burst[2] = '{255, 15, 30};
        burst[3] = '{1, 1, 0};
        full[0]  = '{99, 9, 18};
        full[1]  = '{16, 4, 0};
        full[2]  = '{15, 3, 6};
        full[3]  = '{50, 7, 1};
        full[4]  = '{81, 9, 0};
        full[5]  = '{7, 2, 3};

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.sq_busy   = 1'b0;
        bus.sq_valid  = 1'b0;
        bus.sq_root   = '0;
        bus.sq_rem    = '0;
        bus.out_ready = 1'b0;

        @(negedge clk);
        check_reset_values("reset");

        // Single op, push on the first edge after reset release.
        rst = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = W'(144);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("single_count_after_push", int'(bus.count), 1);
        check("single_no_start_yet", int'(bus.sq_start), 0);
        @(negedge clk);
        check("single_start", int'(bus.sq_start), 1);
        check("single_sq_rad", int'(bus.sq_rad), 144);
        check("single_count_after_pop", int'(bus.count), 0);
        @(negedge clk);
        check("single_start_drop", int'(bus.sq_start), 0);
        bus.sq_valid = 1'b1;
        bus.sq_root  = W'(12);
        bus.sq_rem   = W'(0);
        @(negedge clk);
        check("single_out_valid", int'(bus.out_valid), 1);
        check("single_out_rad", int'(bus.out_rad), 144);
        check("single_out_root", int'(bus.out_root), 12);
        check("single_out_rem", int'(bus.out_rem), 0);
        bus.sq_root = W'(77);
        @(negedge clk);
        bus.sq_valid = 1'b0;
        check("hold_ignores_sq_valid", int'(bus.out_root), 12);
        check("hold_out_valid", int'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("single_release", int'(bus.out_valid), 0);

        // Burst queued while sq_busy blocks issue, then drained in order.
        bus.sq_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = W'(burst[i].rad);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("busy_count_full", int'(bus.count), 4);
        check("busy_in_ready", int'(bus.in_ready), 0);
        for (int i = 0; i < 3; i++) begin
            check("busy_no_start", int'(bus.sq_start), 0);
            @(negedge clk);
        end
        bus.sq_busy = 1'b0;
        for (int i = 0; i < 4; i++) serve(burst[i], 1'b1);
        @(negedge clk);
        check("burst_drained_valid", int'(bus.out_valid), 0);
        check("burst_drained_count", int'(bus.count), 0);

        // Full FIFO with downstream stalled.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = W'(full[0].rad);
        @(negedge clk);
        check("full_count1", int'(bus.count), 1);
        bus.in_data = W'(full[1].rad);
        @(negedge clk);
        check("full_push_pop_count", int'(bus.count), 1);
        check("full_first_start", int'(bus.sq_start), 1);
        check("full_first_rad", int'(bus.sq_rad), full[0].rad);
        for (int k = 2; k < 5; k++) begin
            bus.in_data = W'(full[k].rad);
            @(negedge clk);
            check("full_count_grow", int'(bus.count), k);
        end
        bus.in_data = W'(full[5].rad);
        check("full_in_ready_low", int'(bus.in_ready), 0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("full_no_push", int'(bus.count), 4);
            check("full_no_start", int'(bus.sq_start), 0);
        end
        bus.sq_valid = 1'b1;
        bus.sq_root  = W'(9);
        bus.sq_rem   = W'(18);
        @(negedge clk);
        bus.sq_valid = 1'b0;
        check("full_out_valid", int'(bus.out_valid), 1);
        check("full_out_rad", int'(bus.out_rad), 99);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("backpressure_stable", int'(bus.out_valid && bus.out_rad == W'(99) &&
                  bus.out_root == W'(9) && bus.out_rem == W'(18) && !bus.sq_start &&
                  bus.count == 3'(4)), 1);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_valid", int'(bus.out_valid), 0);
        check("bp_release_count", int'(bus.count), 4);
        @(negedge clk);
        check("bp_next_start", int'(bus.sq_start), 1);
        check("bp_next_rad", int'(bus.sq_rad), full[1].rad);
        check("bp_next_count", int'(bus.count), 3);
        check("bp_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("held_push_accepted", int'(bus.count), 4);
        serve(full[1], 1'b0);
        for (int k = 2; k < 6; k++) serve(full[k], 1'b1);
        @(negedge clk);
        check("full_drained_count", int'(bus.count), 0);
        check("full_drained_valid", int'(bus.out_valid), 0);

        // Reset while waiting on sqrt_int, then a stray result.
        bus.in_valid = 1'b1;
        bus.in_data  = W'(200);
        @(negedge clk);
        bus.in_data = W'(255);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("abort_start", int'(bus.sq_start), 1);
        @(negedge clk);
        check("abort_pending", int'(bus.count), 1);
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst = 1'b0;
        bus.sq_valid = 1'b1;
        bus.sq_root  = W'(14);
        bus.sq_rem   = W'(4);
        @(negedge clk);
        bus.sq_valid = 1'b0;
        check_reset_values("stray");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stray_quiet", int'(!bus.out_valid && !bus.sq_start), 1);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = W'(144);
        @(negedge clk);
        bus.in_valid = 1'b0;
        serve('{144, 12, 0}, 1'b1);
        @(negedge clk);
        check("final_release", int'(bus.out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sqrt_dispatch.md
SQRT_DISPATCH -- requirements
Module: sqrt_dispatch

Interface
REQ-001 Parameter WIDTH, default 8, radicand/root/remainder width in bits.
REQ-002 Parameter DEPTH, default 4, input FIFO entries; power of two, >= 2.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  upstream radicand present.
REQ-006 in_ready  out  1  FIFO can accept; high iff count < DEPTH.
REQ-007 in_data  in  WIDTH  radicand from upstream.
REQ-008 sq_start  out  1  one-cycle start pulse to sqrt_int.
REQ-009 sq_rad  out  WIDTH  radicand driven to sqrt_int.
REQ-010 sq_busy  in  1  sqrt_int calculation in progress.
REQ-011 sq_valid  in  1  sqrt_int root/rem valid.
REQ-012 sq_root  in  WIDTH  root from sqrt_int.
REQ-013 sq_rem  in  WIDTH  remainder from sqrt_int.
REQ-014 out_valid  out  1  result held for downstream.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 out_rad  out  WIDTH  radicand belonging to the result.
REQ-017 out_root  out  WIDTH  captured root.
REQ-018 out_rem  out  WIDTH  captured remainder.
REQ-019 count  out  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-020 FIFO push when in_valid && in_ready; in_data stored at write pointer; pointer wraps DEPTH-1 -> 0.
REQ-021 in_valid while full: no push, no state change, data not lost upstream (in_ready=0); no full-bypass.
REQ-022 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-023 FSM states IDLE, ISSUE, WAIT, HOLD; one operation outstanding at a time.
REQ-024 IDLE -> ISSUE when count > 0 && !sq_busy; FIFO head popped into sq_rad register on that edge.
REQ-025 ISSUE: sq_start = 1 for exactly this one cycle; -> WAIT next edge unconditionally.
REQ-026 sq_start registered, 0 in every state but ISSUE.
REQ-027 sq_rad held stable from ISSUE until the next pop.
REQ-028 WAIT: on sq_valid capture sq_root, sq_rem, sq_rad into out_root, out_rem, out_rad; out_valid = 1 next cycle; -> HOLD.
REQ-029 WAIT with sq_valid low: stay, no timeout.
REQ-030 HOLD: out_* stable while out_valid && !out_ready; on out_ready, out_valid -> 0 and -> IDLE.
REQ-031 sq_valid in IDLE, ISSUE or HOLD ignored.
REQ-032 Latency, empty FIFO, IDLE, sq_busy=0: push at edge T -> sq_start high in cycle T+2; sq_valid at edge S -> out_valid high from S+1.
REQ-033 Results leave in push order; no reordering or dropping.
REQ-034 No arithmetic on data; widths passed unchanged.

Reset
REQ-035 rst high: immediately state=IDLE, pointers=0, count=0, sq_start=0, sq_rad=0, out_valid=0, out_rad/out_root/out_rem=0, in_ready=1.
REQ-036 Reset mid-operation (ISSUE/WAIT/HOLD) discards FIFO contents and pending result; sq_valid from the aborted operation after rst release ignored.
REQ-037 First push accepted on the first rising edge after rst deasserts.

Verification
REQ-038 Single op: push 144, sqrt model returns root 12 rem 0 -> one sq_start pulse with sq_rad=144; out_valid with out_rad=144, out_root=12, out_rem=0.
REQ-039 Burst: push 0, 200, 255, 1 back-to-back, out_ready=1 -> results (0,0),(14,4),(15,30),(1,0) in order, one start per op.
REQ-040 Full FIFO: out_ready=0, push 6 values with DEPTH=4 -> 1 issued, 4 buffered, in_ready=0 with count=4; 6th held upstream until a pop.
REQ-041 Backpressure: out_ready=0 for 10 cycles in HOLD -> out_* stable, no new sq_start; out_ready=1 -> next op issues.
REQ-042 sq_busy=1 held with FIFO non-empty -> no sq_start until sq_busy falls.
REQ-043 rst in WAIT, then stray sq_valid -> all outputs at reset values, out_valid stays 0.
